// File: rtl/board_row_renderer_if.sv
// Row fetch handshake between the row renderer (master) and the board-state block (slave).
// The master raises row_req with row_addr held stable; the slave answers with a
// single-cycle row_ack carrying the packed row in row_data.
interface board_row_renderer_if #(
  parameter int DATA_W = 40
);
  logic              row_req;
  logic [4:0]        row_addr;
  logic              row_ack;
  logic [DATA_W-1:0] row_data;

  modport master (output row_req, output row_addr, input row_ack, input row_data);
  modport slave  (input row_req, input row_addr, output row_ack, output row_data);
endinterface

// File: rtl/board_row_renderer.sv
// Tetris board renderer: draws a BOARD_W x BOARD_H cell grid at (X0,Y0) with square
// size SQ, optional grid lines and a fixed palette; side colour outside the board.
// Board rows are double-buffered (front = displayed, back = next) and fetched over
// a req/ack handshake. Pixel colour is registered (1-cycle latency).
//
// state  | meaning
// S_IDLE | no fetch outstanding, row_req low
// S_REQ  | row_req high, row_addr held until row_ack
module board_row_renderer #(
  parameter int BOARD_W   = 10,
  parameter int BOARD_H   = 20,
  parameter int SQ        = 16,
  parameter int X0        = 160,
  parameter int Y0        = 0,
  parameter int CELL_BITS = 4,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic                  line_end,
  input  logic                  frame_start,
  input  logic                  grid_en,
  input  logic [23:0]           side_color,
  board_row_renderer_if.master  row_if,
  output logic [7:0]            Red,
  output logic [7:0]            Green,
  output logic [7:0]            Blue,
  output logic                  fetch_err
);

  localparam int ROW_W = BOARD_W * CELL_BITS;
  localparam int COL_W = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;

  localparam logic [15:0] L_X0  = 16'(X0);
  localparam logic [15:0] L_XE  = 16'(X0 + BOARD_W * SQ);
  localparam logic [15:0] L_Y0  = 16'(Y0);
  localparam logic [15:0] L_YF  = 16'(Y0 + SQ);
  localparam logic [15:0] L_YE  = 16'(Y0 + BOARD_H * SQ);
  localparam logic [15:0] L_SQ  = 16'(SQ);
  localparam logic [15:0] L_HA  = 16'(H_ACTIVE);
  localparam logic [15:0] L_VA  = 16'(V_ACTIVE);
  localparam logic [15:0] L_BH  = 16'(BOARD_H);
  localparam logic [15:0] L_CB  = 16'(CELL_BITS);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  logic [0:0]       r_state;
  logic [4:0]       r_row_addr;
  logic [4:0]       r_cur_row;
  logic [ROW_W-1:0] r_front;
  logic [ROW_W-1:0] r_back;
  logic             r_front_valid;
  logic             r_back_valid;
  logic             r_restart;
  logic             r_fetch_err;
  logic [23:0]      r_rgb;

  logic [15:0]          w_x, w_y, w_y1, w_y1_rel, w_dx, w_dy;
  logic [15:0]          w_ack_next, w_adv_next;
  logic                 w_bnd_rng, w_boundary, w_ack, w_fv_eff;
  logic                 w_ack_more, w_adv_more;
  logic                 w_in_active, w_in_board, w_grid;
  logic [COL_W-1:0]     w_col;
  logic [CELL_BITS-1:0] w_cell;

  // Row boundary: the line about to start is the first line of a new board row.
  assign w_x       = {6'd0, DrawX};
  assign w_y       = {6'd0, DrawY};
  assign w_y1      = w_y + 16'd1;
  assign w_bnd_rng = line_end && (w_y1 >= L_YF) && (w_y1 < L_YE);
  assign w_y1_rel  = w_bnd_rng ? (w_y1 - L_Y0) : 16'd0;
  assign w_boundary = w_bnd_rng && ((w_y1_rel % L_SQ) == 16'd0);

  // An ack only counts while a request is outstanding. An underrun on the same
  // cycle empties the front, so the arriving row must land there.
  assign w_ack      = row_if.row_ack && (r_state == S_REQ);
  assign w_fv_eff   = r_front_valid && !(w_boundary && !r_back_valid);
  assign w_ack_next = 16'(r_row_addr) + 16'd1;
  assign w_adv_next = 16'(r_cur_row) + 16'd2;
  assign w_ack_more = w_ack_next < L_BH;
  assign w_adv_more = w_adv_next < L_BH;

  // Pixel geometry; offsets are only formed once the pixel is known to be inside the board.
  assign w_in_active = (w_x < L_HA) && (w_y < L_VA);
  assign w_in_board  = (w_x >= L_X0) && (w_x < L_XE) && (w_y >= L_Y0) && (w_y < L_YE);
  assign w_dx        = w_in_board ? (w_x - L_X0) : 16'd0;
  assign w_dy        = w_in_board ? (w_y - L_Y0) : 16'd0;
  assign w_grid      = grid_en && (((w_dx % L_SQ) == 16'd0) || ((w_dy % L_SQ) == 16'd0));
  assign w_col       = COL_W'(w_dx / L_SQ);
  assign w_cell      = CELL_BITS'(r_front >> (16'(w_col) * L_CB));

  function automatic logic [23:0] palette(input logic [3:0] idx);
    case (idx)
      4'd0:    palette = 24'h000000;
      4'd1:    palette = 24'h00FFFF;
      4'd2:    palette = 24'hFFFF00;
      4'd3:    palette = 24'h800080;
      4'd4:    palette = 24'h00FF00;
      4'd5:    palette = 24'hFF0000;
      4'd6:    palette = 24'h0000FF;
      4'd7:    palette = 24'hFF8000;
      default: palette = 24'h808080;
    endcase
  endfunction

  // Fetch FSM, buffer swap at row boundaries and sticky underrun flag.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state       <= S_IDLE;
      r_row_addr    <= '0;
      r_cur_row     <= '0;
      r_front       <= '0;
      r_back        <= '0;
      r_front_valid <= 1'b0;
      r_back_valid  <= 1'b0;
      r_restart     <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else if (frame_start) begin
      r_front_valid <= 1'b0;
      r_back_valid  <= 1'b0;
      r_cur_row     <= '0;
      if (r_state == S_IDLE) begin
        r_state    <= S_REQ;
        r_row_addr <= '0;
        r_restart  <= 1'b0;
      end else if (w_ack) begin
        // the in-flight row belongs to the old frame: drop it and ask for row 0
        r_row_addr <= '0;
        r_restart  <= 1'b0;
      end else begin
        r_restart  <= 1'b1;
      end
    end else begin
      if (w_boundary) begin
        r_cur_row <= r_cur_row + 5'd1;
        if (r_back_valid) begin
          r_front       <= r_back;
          r_front_valid <= 1'b1;
          r_back_valid  <= 1'b0;
          if ((r_state == S_IDLE) && w_adv_more) begin
            r_state    <= S_REQ;
            r_row_addr <= 5'(w_adv_next);
          end
        end else begin
          r_fetch_err   <= 1'b1;
          r_front_valid <= 1'b0;
        end
      end
      if (w_ack) begin
        if (r_restart) begin
          r_restart  <= 1'b0;
          r_row_addr <= '0;
        end else if (!w_fv_eff) begin
          r_front       <= row_if.row_data;
          r_front_valid <= 1'b1;
          if (w_ack_more && !r_back_valid) r_row_addr <= 5'(w_ack_next);
          else                             r_state    <= S_IDLE;
        end else begin
          r_back       <= row_if.row_data;
          r_back_valid <= 1'b1;
          r_state      <= S_IDLE;
        end
      end
    end
  end

  // Registered pixel colour in priority order: blanking, side bar, grid, empty row, palette.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)              r_rgb <= '0;
    else if (!w_in_active)   r_rgb <= 24'h000000;
    else if (!w_in_board)    r_rgb <= side_color;
    else if (w_grid)         r_rgb <= 24'h404040;
    else if (!r_front_valid) r_rgb <= 24'h000000;
    else                     r_rgb <= palette(4'(w_cell));
  end

  assign row_if.row_req  = (r_state == S_REQ);
  assign row_if.row_addr = r_row_addr;
  assign Red             = r_rgb[23:16];
  assign Green           = r_rgb[15:8];
  assign Blue            = r_rgb[7:0];
  assign fetch_err       = r_fetch_err;

endmodule

// File: tb/tb_board_row_renderer.sv
// Self-checking bench for board_row_renderer: a behavioural board/palette model,
// a board-state responder with programmable latency and row hold, and scan-line stimulus.
`timescale 1ns/1ps
module tb_board_row_renderer;
  localparam int BW = 10, BH = 20, SQ = 16, X0 = 160, Y0 = 0, CB = 4, HA = 640, VA = 480;
  localparam int RW = BW * CB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  draw_x = '0, draw_y = '0;
  logic        line_end = 1'b0, frame_start = 1'b0, grid_en = 1'b0;
  logic [23:0] side_color = 24'h00007C;
  logic [7:0]  red, green, blue;
  logic        fetch_err;

  board_row_renderer_if #(.DATA_W(RW)) bus();

  board_row_renderer #(
    .BOARD_W(BW), .BOARD_H(BH), .SQ(SQ), .X0(X0), .Y0(Y0),
    .CELL_BITS(CB), .H_ACTIVE(HA), .V_ACTIVE(VA)
  ) dut (
    .Clk(clk), .Reset(rst_n), .DrawX(draw_x), .DrawY(draw_y),
    .line_end(line_end), .frame_start(frame_start), .grid_en(grid_en),
    .side_color(side_color), .row_if(bus),
    .Red(red), .Green(green), .Blue(blue), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int board [BH][BW];
  bit row_ok [BH];
  int palette_ref [16];
  int lat = 3;
  bit hold_en = 1'b0;
  int hold_row = 0;
  bit discard_next = 1'b0;
  int ack_log [$];
  int max_addr = 0;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack_row(input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int c = 0; c < BW; c++) v[c*CB +: CB] = CB'(board[r][c]);
    return v;
  endfunction

  // Expected colour from the geometric rules; row_ok says whether the displayed row has arrived.
  function automatic logic [23:0] exp_pix(input int x, input int y);
    int row, col;
    if (x >= HA || y >= VA) return 24'h0;
    if (x < X0 || x >= X0 + BW*SQ || y < Y0 || y >= Y0 + BH*SQ) return side_color;
    if (grid_en && (((x - X0) % SQ) == 0 || ((y - Y0) % SQ) == 0)) return 24'h404040;
    row = (y - Y0) / SQ;
    col = (x - X0) / SQ;
    if (!row_ok[row]) return 24'h0;
    return 24'(palette_ref[board[row][col]]);
  endfunction

  function automatic void fill_board();
    for (int r = 0; r < BH; r++)
      for (int c = 0; c < BW; c++) board[r][c] = int'($urandom_range(0, 15));
  endfunction

  // Board-state responder: answers a request after lat cycles unless that row is held.
  initial begin : responder
    int cnt;
    cnt = 0;
    bus.row_ack  = 1'b0;
    bus.row_data = '0;
    forever begin
      @(negedge clk);
      bus.row_ack = 1'b0;
      if (rst_n && bus.row_req && !(hold_en && int'(bus.row_addr) == hold_row)) begin
        if (cnt >= lat) begin
          bus.row_ack  = 1'b1;
          bus.row_data = pack_row(int'(bus.row_addr));
          cnt = 0;
          if (discard_next) discard_next = 1'b0;
          else begin
            row_ok[int'(bus.row_addr)] = 1'b1;
            ack_log.push_back(int'(bus.row_addr));
          end
        end else cnt++;
      end else cnt = 0;
    end
  end

  always @(posedge clk)
    if (rst_n && bus.row_req && int'(bus.row_addr) > max_addr) max_addr = int'(bus.row_addr);

  task automatic drive(input int x, input int y, input bit le, input bit fs, input bit do_chk);
    logic [23:0] e;
    @(negedge clk);
    draw_x = 10'(x);
    draw_y = 10'(y);
    line_end = le;
    frame_start = fs;
    e = exp_pix(x, y);
    @(posedge clk);
    #1;
    line_end = 1'b0;
    frame_start = 1'b0;
    if (do_chk) check_val($sformatf("pix(%0d,%0d)", x, y), {8'h0, red, green, blue}, {8'h0, e});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(HA + 60, VA + 20, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic run_line(input int y, input int npix);
    int x;
    for (int k = 0; k < npix; k++) begin
      if ($urandom_range(0, 9) < 7) x = int'($urandom_range(X0, X0 + BW*SQ - 1));
      else                          x = int'($urandom_range(0, 799));
      grid_en = 1'($urandom_range(0, 1));
      drive(x, y, 1'b0, 1'b0, 1'b1);
    end
    drive(HA + 8, y, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic start_frame();
    for (int r = 0; r < BH; r++) row_ok[r] = 1'b0;
    drive(HA + 60, VA + 20, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic wait_ack(input int maxc, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(posedge clk);
      if (bus.row_ack) seen = 1'b1;
    end
    #1;
    check_val(tag, 32'(seen), 32'd1);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    palette_ref = '{24'h000000, 24'h00FFFF, 24'hFFFF00, 24'h800080,
                    24'h00FF00, 24'hFF0000, 24'h0000FF, 24'hFF8000,
                    24'h808080, 24'h808080, 24'h808080, 24'h808080,
                    24'h808080, 24'h808080, 24'h808080, 24'h808080};
    fill_board();
    board[0][3] = 5;
    board[0][0] = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_req",  32'(bus.row_req),  32'd0);
    check_val("rst_addr", 32'(bus.row_addr), 32'd0);
    check_val("rst_rgb",  {8'h0, red, green, blue}, 32'd0);
    check_val("rst_ferr", 32'(fetch_err), 32'd0);
    #2 rst_n = 1'b1;
    idle(3);
    check_val("no_req_before_fs", 32'(bus.row_req), 32'd0);

    // first frame: first ack after a longer latency, then 3-cycle acks
    lat = 4;
    grid_en = 1'b0;
    side_color = 24'h00007C;
    ack_log.delete();
    max_addr = 0;
    start_frame();
    check_val("fs_req",  32'(bus.row_req),  32'd1);
    check_val("fs_addr", 32'(bus.row_addr), 32'd0);
    wait_ack(20, "ack_row0");
    lat = 3;
    check_val("row1_req",  32'(bus.row_req),  32'd1);
    check_val("row1_addr", 32'(bus.row_addr), 32'd1);
    idle(10);
    for (int y = 0; y < VA; y++) begin
      if (y == 1) begin grid_en = 1'b0; drive(X0 + 1, Y0 + 1, 1'b0, 1'b0, 1'b1); end
      if (y == 2) begin
        grid_en = 1'b0;
        drive(X0 + 3*16 + 5, Y0 + 2, 1'b0, 1'b0, 1'b1);
        check_val("cell3_red", {8'h0, red, green, blue}, 32'h00FF0000);
      end
      if (y == 5) begin
        grid_en = 1'b1; drive(X0 + 32, Y0 + 5, 1'b0, 1'b0, 1'b1);
        grid_en = 1'b0; drive(X0 + 32, Y0 + 5, 1'b0, 1'b0, 1'b1);
        drive(100, Y0 + 5, 1'b0, 1'b0, 1'b1);
        drive(700, Y0 + 5, 1'b0, 1'b0, 1'b1);
      end
      run_line(y, (y < Y0 + BH*SQ) ? 4 : 1);
    end
    check_val("f1_ferr", 32'(fetch_err), 32'd0);
    check_val("f1_max_addr", 32'(max_addr), 32'(BH - 1));
    check_val("f1_ack_count", 32'(ack_log.size()), 32'(BH));
    for (int i = 0; i < ack_log.size() && i < BH; i++)
      check_val($sformatf("f1_ack_order%0d", i), 32'(ack_log[i]), 32'(i));

    // second frame: row 2 withheld past its boundary
    fill_board();
    side_color = 24'($urandom) | 24'h1;
    ack_log.delete();
    hold_row = 2;
    hold_en = 1'b1;
    start_frame();
    idle(12);
    for (int y = 0; y < 34; y++) begin
      run_line(y, 4);
      if (y == 15) check_val("ferr_before", 32'(fetch_err), 32'd0);
      if (y == 31) begin
        check_val("ferr_underrun", 32'(fetch_err), 32'd1);
        check_val("held_addr", 32'(bus.row_addr), 32'd2);
      end
    end
    grid_en = 1'b0;
    drive(X0 + 16 + 8, 33, 1'b0, 1'b0, 1'b1);
    check_val("row2_blank", {8'h0, red, green, blue}, 32'd0);
    hold_en = 1'b0;
    wait_ack(20, "ack_row2_late");
    idle(2);
    for (int y = 34; y < VA; y++) run_line(y, (y < Y0 + BH*SQ) ? 4 : 1);
    check_val("ferr_sticky", 32'(fetch_err), 32'd1);

    // third frame: restart while row 7 is outstanding
    fill_board();
    ack_log.delete();
    hold_row = 7;
    hold_en = 1'b1;
    start_frame();
    idle(12);
    for (int y = 0; y < 100; y++) run_line(y, 2);
    check_val("r7_req",  32'(bus.row_req),  32'd1);
    check_val("r7_addr", 32'(bus.row_addr), 32'd7);
    start_frame();
    check_val("restart_req_kept",  32'(bus.row_req),  32'd1);
    check_val("restart_addr_kept", 32'(bus.row_addr), 32'd7);
    discard_next = 1'b1;
    hold_en = 1'b0;
    wait_ack(20, "ack_stale7");
    check_val("restart_req",  32'(bus.row_req),  32'd1);
    check_val("restart_addr", 32'(bus.row_addr), 32'd0);
    idle(12);
    for (int y = 0; y < 40; y++) run_line(y, 4);
    check_val("restart_log0", (ack_log.size() > 7) ? 32'(ack_log[7]) : 32'hFFFF_FFFF, 32'd0);
    check_val("restart_log1", (ack_log.size() > 8) ? 32'(ack_log[8]) : 32'hFFFF_FFFF, 32'd1);

    // reset while a request is outstanding
    hold_row = 0;
    hold_en = 1'b1;
    side_color = 24'hA5C3E1;
    start_frame();
    check_val("pre_rst_req", 32'(bus.row_req), 32'd1);
    drive(100, 100, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("async_rst_req",  32'(bus.row_req),  32'd0);
    check_val("async_rst_addr", 32'(bus.row_addr), 32'd0);
    check_val("async_rst_rgb",  {8'h0, red, green, blue}, 32'd0);
    check_val("async_rst_ferr", 32'(fetch_err), 32'd0);
    #2 rst_n = 1'b1;
    hold_en = 1'b0;
    idle(10);
    check_val("post_rst_no_req", 32'(bus.row_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
